pwm_width_meter: RTL

//  Downstream monitor for the PWM output stage. It measures, per frame, how many counter-clock

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_chan_counter.sv | 77 +++++++
 rtl/pwm_width_meter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared types and helpers for the PWM width meter.
//   meter_state_t : frame FSM states (IDLE, MEASURE, DRAIN)
//   cnt_max()     : saturation value of an unsigned counter of a given width
// ---------------------------------------------------------------------------
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DRAIN   = 2'd2
  } meter_state_t;

  // Largest value representable in dwidth unsigned bits.
  function automatic int unsigned cnt_max(input int unsigned dwidth);
    return (32'd1 << dwidth) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_chan_counter.sv
// ---------------------------------------------------------------------------
// pwm_chan_counter
// Saturating high-time counter for one PWM channel.
// Ports:
//   i_clk      : counter clock
//   i_rst      : synchronous active-high reset
//   i_load     : frame start; count restarts at the current channel level
//   i_en       : measuring window active (accumulate while i_level is high)
//   i_final    : last sampled cycle of a timed-out window
//   i_level    : channel PWM level
//   o_cnt_nxt  : value the count takes at the next edge
//   o_sat_nxt  : value the saturation flag takes at the next edge
// The next-state values are exported so the parent can snapshot the result
// in the same cycle the window closes, including that cycle's sample.
// ---------------------------------------------------------------------------
module pwm_chan_counter
  import pwm_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_en,
  input  logic              i_final,
  input  logic              i_level,
  output logic [DWIDTH-1:0] o_cnt_nxt,
  output logic              o_sat_nxt
);

  localparam logic [DWIDTH-1:0] CNT_MAX = DWIDTH'(cnt_max(DWIDTH));
  localparam logic [DWIDTH-1:0] D_ZERO  = {DWIDTH{1'b0}};
  localparam logic [DWIDTH-1:0] D_ONE   = {{(DWIDTH-1){1'b0}}, 1'b1};

  logic [DWIDTH-1:0] r_cnt;
  logic              r_sat;
  logic [DWIDTH-1:0] w_cnt_nxt;
  logic              w_sat_nxt;

  // Next count / saturation flag from load, enable and the current level.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    if (i_load) begin
      // The frame-start cycle is itself a sample.
      w_cnt_nxt = {{(DWIDTH-1){1'b0}}, i_level};
      w_sat_nxt = 1'b0;
    end else if (i_en && i_level) begin
      if (r_cnt == CNT_MAX) begin
        w_cnt_nxt = r_cnt;
        w_sat_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + D_ONE;
        // Still high when the window times out: the true width is unknown.
        w_sat_nxt = r_sat | i_final;
      end
    end else begin
      w_cnt_nxt = r_cnt;
      w_sat_nxt = r_sat;
    end
  end

  // Count and saturation registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= D_ZERO;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= w_sat_nxt;
    end
  end

  assign o_cnt_nxt = w_cnt_nxt;
  assign o_sat_nxt = w_sat_nxt;

endmodule

// File: rtl/pwm_width_meter.sv
// ---------------------------------------------------------------------------
// pwm_width_meter
// Measures, per hsync frame, how many clock cycles each PWM channel is high,
// then streams the STAGE results out one channel per valid/ready beat.
// Ports:
//   clkforcounter : PWM counter clock
//   rst           : synchronous active-high reset
//   hsync         : frame start from the PWM stage
//   pwm_in        : channel levels, pwm_in[k] is channel k
//   res_valid     : result beat valid
//   res_ready     : consumer accepts a beat when res_valid & res_ready
//   res_data      : high-cycle count of channel res_idx
//   res_idx       : channel index of the current beat
//   res_sat       : count of channel res_idx saturated or timed out
//   frame_done    : one-cycle pulse after the last beat is accepted
//   overrun       : sticky, hsync seen while results were draining
// ---------------------------------------------------------------------------
module pwm_width_meter
  import pwm_pkg::*;
#(
  parameter  int STAGE  = 8,
  parameter  int DWIDTH = 8,
  localparam int IWIDTH = $clog2(STAGE)
) (
  input  logic              clkforcounter,
  input  logic              rst,
  input  logic              hsync,
  input  logic [0:STAGE-1]  pwm_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] res_data,
  output logic [IWIDTH-1:0] res_idx,
  output logic              res_sat,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [DWIDTH-1:0] CNT_MAX  = DWIDTH'(cnt_max(DWIDTH));
  localparam logic [DWIDTH-1:0] D_ZERO   = {DWIDTH{1'b0}};
  localparam logic [DWIDTH-1:0] D_ONE    = {{(DWIDTH-1){1'b0}}, 1'b1};
  localparam logic [IWIDTH-1:0] I_ZERO   = {IWIDTH{1'b0}};
  localparam logic [IWIDTH-1:0] I_ONE    = {{(IWIDTH-1){1'b0}}, 1'b1};
  localparam logic [IWIDTH-1:0] LAST_IDX = IWIDTH'(STAGE - 1);

  meter_state_t      r_state;
  logic [DWIDTH-1:0] r_wcnt;
  logic [DWIDTH-1:0] r_res_cnt [STAGE];
  logic [STAGE-1:0]  r_res_sat;
  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic [IWIDTH-1:0] r_idx;
  logic              r_sat;
  logic              r_frame_done;
  logic              r_overrun;

  logic              w_load;
  logic              w_meas_en;
  logic              w_timeout;
  logic              w_exit;
  logic              w_accept;
  logic              w_last;
  logic [DWIDTH-1:0] w_wcnt_inc;
  logic [IWIDTH-1:0] w_idx_inc;
  logic [DWIDTH-1:0] w_cnt_nxt [STAGE];
  logic [STAGE-1:0]  w_sat_nxt;

  // Per-state control strobes for the counters and the FSM.
  always_comb begin
    w_load     = 1'b0;
    w_meas_en  = 1'b0;
    w_timeout  = 1'b0;
    w_exit     = 1'b0;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    w_wcnt_inc = r_wcnt + D_ONE;
    w_idx_inc  = r_idx + I_ONE;
    case (r_state)
      IDLE: begin
        w_load = hsync;
      end
      MEASURE: begin
        if (hsync) begin
          // Restart: the partial frame is thrown away.
          w_load = 1'b1;
        end else begin
          w_meas_en = 1'b1;
          // The hsync cycle is sample 1 and leaves wcnt at 0, so the window
          // closes on the cycle that brings wcnt to CNT_MAX, i.e. after
          // CNT_MAX+1 sampled cycles in total.
          w_timeout = (w_wcnt_inc == CNT_MAX);
          w_exit    = w_timeout || (pwm_in == {STAGE{1'b0}});
        end
      end
      DRAIN: begin
        w_accept = r_valid && res_ready;
        w_last   = w_accept && (r_idx == LAST_IDX);
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  for (genvar k = 0; k < STAGE; k++) begin : g_chan
    pwm_chan_counter #(
      .DWIDTH (DWIDTH)
    ) u_chan_counter (
      .i_clk     (clkforcounter),
      .i_rst     (rst),
      .i_load    (w_load),
      .i_en      (w_meas_en),
      .i_final   (w_timeout),
      .i_level   (pwm_in[k]),
      .o_cnt_nxt (w_cnt_nxt[k]),
      .o_sat_nxt (w_sat_nxt[k])
    );
  end

  // Frame FSM, window counter, result snapshot and output beat registers.
  always_ff @(posedge clkforcounter) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wcnt       <= D_ZERO;
      for (int k = 0; k < STAGE; k++) begin
        r_res_cnt[k] <= D_ZERO;
      end
      r_res_sat    <= {STAGE{1'b0}};
      r_valid      <= 1'b0;
      r_data       <= D_ZERO;
      r_idx        <= I_ZERO;
      r_sat        <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hsync) begin
            r_state <= MEASURE;
            r_wcnt  <= D_ZERO;
          end
        end
        MEASURE: begin
          if (hsync) begin
            r_wcnt <= D_ZERO;
          end else if (w_exit) begin
            r_state <= DRAIN;
            for (int k = 0; k < STAGE; k++) begin
              r_res_cnt[k] <= w_cnt_nxt[k];
            end
            r_res_sat <= w_sat_nxt;
            // Beat 0 comes straight from the snapshot values.
            r_valid   <= 1'b1;
            r_idx     <= I_ZERO;
            r_data    <= w_cnt_nxt[0];
            r_sat     <= w_sat_nxt[0];
          end else begin
            r_wcnt <= w_wcnt_inc;
          end
        end
        DRAIN: begin
          // A new frame cannot be measured while results are pending.
          if (hsync) begin
            r_overrun <= 1'b1;
          end
          if (w_last) begin
            r_state      <= IDLE;
            r_valid      <= 1'b0;
            r_idx        <= I_ZERO;
            r_data       <= D_ZERO;
            r_sat        <= 1'b0;
            r_frame_done <= 1'b1;
          end else if (w_accept) begin
            r_idx  <= w_idx_inc;
            r_data <= r_res_cnt[w_idx_inc];
            r_sat  <= r_res_sat[w_idx_inc];
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign res_valid  = r_valid;
  assign res_data   = r_data;
  assign res_idx    = r_idx;
  assign res_sat    = r_sat;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule
